simple_dp_bram_be: RTL

- Next-generation simple dual-port block RAM: one write port, one read port, one clock.
- Adds per-byte write enables and a selectable read latency of 1 or 2 cycles, with DOUT_VALID tracking each read.
- Adds a selectable read/write collision policy and a hardware clear sequencer that sweeps INIT_VAL into every word.
- Used as the storage primitive under packet buffers and FIFOs that need partial-word updates and an in-run memory wipe.

---
 rtl/simple_dp_bram_be.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/simple_dp_bram_be.sv
// Simple dual-port RAM: byte-lane writes, reads with 1 or 2 cycles of latency, and a clear sweep that fills every word with INIT_VAL.
// Latency: DOUT/DOUT_VALID follow RD_EN by RD_LATENCY edges. The clear sweep takes 2**PTR_WIDTH cycles.
// Backpressure: there is none on the ports. WR_EN and RD_EN are dropped while BUSY is high.
// Ports: CLK, RESET_N | WR_EN, WR_BE, WR_PTR, DIN | RD_EN, RD_PTR -> DOUT, DOUT_VALID | CLEAR_REQ -> BUSY, CLEAR_DONE
module simple_dp_bram_be #(
  parameter int                    DATA_WIDTH  = 72,
  parameter int                    BYTE_WIDTH  = 9,
  parameter int                    PTR_WIDTH   = 3,
  parameter int                    RD_LATENCY  = 1,   // 2 selects the extra register stage; anything else acts as 1
  parameter int                    WRITE_FIRST = 0,   // 0: read returns the old word; 1: read returns the merged new word
  parameter logic [DATA_WIDTH-1:0] INIT_VAL    = '1,
  localparam int                   NB          = DATA_WIDTH / BYTE_WIDTH,
  localparam int                   DEPTH       = 2 ** PTR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  WR_EN,
  input  logic [NB-1:0]         WR_BE,
  input  logic [PTR_WIDTH-1:0]  WR_PTR,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  RD_EN,
  input  logic [PTR_WIDTH-1:0]  RD_PTR,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  input  logic                  CLEAR_REQ,
  output logic                  BUSY,
  output logic                  CLEAR_DONE
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                state_q, state_d;
  logic [PTR_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_vld_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_fire;
  logic                  wr_fire;

  // Storage. It powers up holding INIT_VAL, and reset never touches it.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

  function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [NB-1:0]         be);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) r[k*BYTE_WIDTH +: BYTE_WIDTH] = new_w[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return r;
  endfunction

  // User ports are served only in IDLE. A CLEAR_REQ cycle still serves its write and its read.
  assign rd_fire = (state_q == S_IDLE) && RD_EN;
  assign wr_fire = (state_q == S_IDLE) && WR_EN;

  // Clear sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CLEAR_REQ) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + PTR_WIDTH'(1);
        // This edge writes the last address, so the sweep ends here.
        if (&cnt_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Write port. The sweep has exclusive use of the array while it runs.
  always_ff @(posedge CLK) begin
    if (state_q == S_CLEAR) begin
      mem_q[cnt_q] <= INIT_VAL;
    end else if (wr_fire) begin
      for (int k = 0; k < NB; k++) begin
        if (WR_BE[k]) mem_q[WR_PTR][k*BYTE_WIDTH +: BYTE_WIDTH] <= DIN[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Read word. In write-first mode, a same-address write is forwarded lane by lane.
  always_comb begin
    rd_word = mem_q[RD_PTR];
    if ((WRITE_FIRST != 0) && WR_EN && (WR_PTR == RD_PTR)) begin
      rd_word = lane_merge(rd_word, DIN, WR_BE);
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_q;
      logic                  s1_vld_q;
      // The stage-1 read keeps draining during a sweep. The word it holds was read before the sweep began.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          s1_q       <= '0;
          s1_vld_q   <= 1'b0;
          dout_q     <= '0;
          dout_vld_q <= 1'b0;
        end else begin
          s1_vld_q   <= rd_fire;
          if (rd_fire) s1_q <= rd_word;
          dout_vld_q <= s1_vld_q;
          if (s1_vld_q) dout_q <= s1_q;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          dout_q     <= '0;
          dout_vld_q <= 1'b0;
        end else begin
          dout_vld_q <= rd_fire;
          if (rd_fire) dout_q <= rd_word;
        end
      end
    end
  endgenerate

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_vld_q;
  assign BUSY       = (state_q == S_CLEAR);
  assign CLEAR_DONE = done_q;

endmodule
